// File: rtl/controller_regs_m_if.sv
// CPU register-bus interface for controller_regs_m.
// Signals:
//   cpu_rd   - one-cycle read strobe from the CPU
//   cpu_addr - 4-bit register select
//   cpu_data - registered read data returned one cycle after cpu_rd
// Modports: master (CPU side), slave (register block side).
interface controller_regs_m_if;
    logic       cpu_rd;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_data;

    modport master (output cpu_rd, output cpu_addr, input cpu_data);
    modport slave  (input cpu_rd, input cpu_addr, output cpu_data);
endinterface

// File: rtl/controller_regs_m.sv
// Game-controller polling block with CPU-readable button registers.
// On each accepted frame_tick it pulses poll_start, waits for the upstream
// shift logic to settle, then captures every controller byte and records
// sticky press edges (and release edges when CONTROLLER_REGS_RELEASE_EN is
// defined).
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   frame_tick - vblank pulse requesting a poll
//   poll_start - start strobe to the upstream controller interface
//   buttons_in - 8 bits per controller, controller i at [8i+7:8i]
//   cpu        - controller_regs_m_if.slave (cpu_rd, cpu_addr, cpu_data)
//   busy       - high whenever a poll is in progress
// Optional feature macro: CONTROLLER_REGS_RELEASE_EN (adds rel_i registers).
module controller_regs_m #(
    parameter int unsigned NUM_CONTROLLERS = 2,
    parameter int unsigned START_CYCLES    = 9,
    parameter int unsigned SETTLE_CYCLES   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    output logic                         poll_start,
    input  logic [8*NUM_CONTROLLERS-1:0] buttons_in,
    controller_regs_m_if.slave           cpu,
    output logic                         busy
);

`ifdef CONTROLLER_REGS_RELEASE_EN
    localparam int unsigned STRIDE = 3;
`else
    localparam int unsigned STRIDE = 2;
`endif
    localparam int unsigned STATUS_ADDR = STRIDE * NUM_CONTROLLERS;
    localparam int unsigned MAX_CYC     = (START_CYCLES > SETTLE_CYCLES) ? START_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_SETTLE, ST_CAPTURE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             poll_start_q, poll_start_d;
    logic             busy_q, busy_d;
    logic [7:0]       cpu_data_q, cpu_data_d;
    logic             overrun_q, overrun_d;
    logic             rst_dly_q;
    logic [7:0]       cur_q   [NUM_CONTROLLERS];
    logic [7:0]       cur_d   [NUM_CONTROLLERS];
    logic [7:0]       prev_q  [NUM_CONTROLLERS];
    logic [7:0]       prev_d  [NUM_CONTROLLERS];
    logic [7:0]       press_q [NUM_CONTROLLERS];
    logic [7:0]       press_d [NUM_CONTROLLERS];
`ifdef CONTROLLER_REGS_RELEASE_EN
    logic [7:0]       rel_q   [NUM_CONTROLLERS];
    logic [7:0]       rel_d   [NUM_CONTROLLERS];
`endif

    logic tick_ok_c;
    logic capture_c;
    logic rd_status_c;
    logic unused_prev_c;

    // A tick in the first cycle after reset release is dropped.
    assign tick_ok_c   = frame_tick && !rst_dly_q;
    assign capture_c   = (state_q == ST_CAPTURE);
    assign rd_status_c = cpu.cpu_rd && (cpu.cpu_addr == 4'(STATUS_ADDR));

    assign poll_start   = poll_start_q;
    assign busy         = busy_q;
    assign cpu.cpu_data = cpu_data_q;

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            poll_start_q <= 1'b0;
            busy_q       <= 1'b0;
            cpu_data_q   <= 8'h00;
            overrun_q    <= 1'b0;
            rst_dly_q    <= 1'b1;
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                cur_q[i]   <= 8'h00;
                prev_q[i]  <= 8'h00;
                press_q[i] <= 8'h00;
`ifdef CONTROLLER_REGS_RELEASE_EN
                rel_q[i]   <= 8'h00;
`endif
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            poll_start_q <= poll_start_d;
            busy_q       <= busy_d;
            cpu_data_q   <= cpu_data_d;
            overrun_q    <= overrun_d;
            rst_dly_q    <= 1'b0;
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                cur_q[i]   <= cur_d[i];
                prev_q[i]  <= prev_d[i];
                press_q[i] <= press_d[i];
`ifdef CONTROLLER_REGS_RELEASE_EN
                rel_q[i]   <= rel_d[i];
`endif
            end
        end
    end

    // Poll sequencer: next state, phase counter, and look-ahead outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_ok_c) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        poll_start_d = (state_d == ST_START);
        busy_d       = (state_d != ST_IDLE);
    end

    // Sticky overrun; a new overrun beats a same-cycle read-clear.
    always_comb begin
        overrun_d = overrun_q;
        if (rd_status_c) overrun_d = 1'b0;
        if (frame_tick && (state_q != ST_IDLE)) overrun_d = 1'b1;
    end

    // Capture and edge-detect; a read-clear drops old bits, new edges survive.
    always_comb begin
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            cur_d[i]   = cur_q[i];
            prev_d[i]  = prev_q[i];
            press_d[i] = (cpu.cpu_rd && (cpu.cpu_addr == 4'(STRIDE * i + 1))) ? 8'h00 : press_q[i];
`ifdef CONTROLLER_REGS_RELEASE_EN
            rel_d[i]   = (cpu.cpu_rd && (cpu.cpu_addr == 4'(STRIDE * i + 2))) ? 8'h00 : rel_q[i];
`endif
            if (capture_c) begin
                prev_d[i]  = cur_q[i];
                cur_d[i]   = buttons_in[8*i +: 8];
                press_d[i] = press_d[i] | (buttons_in[8*i +: 8] & ~cur_q[i]);
`ifdef CONTROLLER_REGS_RELEASE_EN
                rel_d[i]   = rel_d[i] | (cur_q[i] & ~buttons_in[8*i +: 8]);
`endif
            end
        end
    end

    // Read mux; data holds between reads.
    always_comb begin
        cpu_data_d = cpu_data_q;
        if (cpu.cpu_rd) begin
            cpu_data_d = 8'h00;
            for (int i = 0; i < NUM_CONTROLLERS; i++) begin
                if (cpu.cpu_addr == 4'(STRIDE * i))     cpu_data_d = cur_q[i];
                if (cpu.cpu_addr == 4'(STRIDE * i + 1)) cpu_data_d = press_q[i];
`ifdef CONTROLLER_REGS_RELEASE_EN
                if (cpu.cpu_addr == 4'(STRIDE * i + 2)) cpu_data_d = rel_q[i];
`endif
            end
            if (rd_status_c) cpu_data_d = {6'b0, overrun_q, busy_q};
        end
    end

    // prev_i is retained history with no read path in the register map.
    always_comb begin
        unused_prev_c = 1'b0;
        for (int i = 0; i < NUM_CONTROLLERS; i++) begin
            unused_prev_c = unused_prev_c ^ (^prev_q[i]);
        end
    end

endmodule

// File: doc/controller_regs_m.md
CONTROLLER_REGS_M -- requirements
Module: controller_regs_m

Interface
REQ-001 SHALL have parameter NUM_CONTROLLERS, default 2, the number of controllers polled (1..4).
REQ-002 SHALL have parameter START_CYCLES, default 9, the number of cycles poll_start is held high per poll.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 8, the cycles waited after poll_start falls before capture.
REQ-004 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 frame_tick  input  1  one-cycle pulse requesting a new poll, driven by vblank.
REQ-007 poll_start  output  1  drives the start input of the upstream controller interface.
REQ-008 buttons_in  input  8*NUM_CONTROLLERS  active-high button bytes from the controller interface; controller i occupies bits [8i+7:8i].
REQ-009 cpu_rd  input  1  CPU read strobe, one cycle per read.
REQ-010 cpu_addr  input  4  CPU register select.
REQ-011 cpu_data  output  8  registered read data.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 FSM states SHALL be IDLE, START, SETTLE and CAPTURE.
REQ-014 IDLE SHALL go to START on frame_tick=1.
REQ-015 START SHALL drive poll_start=1 for exactly START_CYCLES cycles, then go to SETTLE.
REQ-016 SETTLE SHALL drive poll_start=0 for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-017 CAPTURE SHALL last one cycle, then return to IDLE.
REQ-018 A frame_tick seen outside IDLE SHALL be ignored and SHALL set the sticky overrun flag.
REQ-019 In CAPTURE, for each controller i: prev_i <= cur_i; cur_i <= buttons_in byte i; press_i <= press_i | (new & ~cur_i).
REQ-020 press_i SHALL hold each bit until a CPU read of that register clears it.
REQ-021 On a simultaneous CAPTURE and read-clear of the same press register, the result SHALL be the edges from this capture only; the old bits are cleared.
REQ-022 Register map without the macro:
- addr 2i = cur_i
- addr 2i+1 = press_i
- addr 2*NUM_CONTROLLERS = status {6'b0, overrun, busy}
- all other addresses read 8'h00.
REQ-023 cpu_data SHALL update on the cycle after cpu_rd=1, with one-cycle latency, and hold its value while cpu_rd=0.
REQ-024 Reading the status register SHALL return the current overrun value and then clear it; an overrun set in the same cycle SHALL win.
REQ-025 Reads SHALL never stall or alter the FSM.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE and set poll_start=0, busy=0 and cpu_data=8'h00.
REQ-027 rst=1 SHALL clear all cur, prev, press (and rel) registers, the overrun flag and the cycle counter.
REQ-028 rst asserted mid-poll SHALL abort the poll with no capture, and poll_start SHALL be low on the following cycle.
REQ-029 frame_tick in the cycle rst is deasserted SHALL be ignored.

Configuration
REQ-030 Macro CONTROLLER_REGS_RELEASE_EN, when defined, SHALL add a sticky rel_i register per controller.
- CAPTURE: rel_i |= cur_i & ~new.
- Read-clear rules same as press_i.
- Map: addr 3i = cur_i, 3i+1 = press_i, 3i+2 = rel_i, 3*NUM_CONTROLLERS = status.
REQ-031 Without CONTROLLER_REGS_RELEASE_EN, no rel logic SHALL exist and the map of REQ-022 SHALL apply.

Verification (NUM_CONTROLLERS=2, defaults, macro undefined unless stated)
REQ-032 Basic poll: frame_tick at cycle 0 -> poll_start high for cycles 1-9 and low for 10-17; CAPTURE at 18; busy low from 19.
REQ-033 Capture and read-clear: buttons_in=16'h7FFE then capture, read addr 0 -> 8'hFE; read addr 1 -> 8'hFE; read addr 3 -> 8'h7F; second read of addr 1 -> 8'h00.
REQ-034 Overrun: second frame_tick while busy -> status read = 8'h03; next status read after idle -> 8'h00; exactly one poll occurs.
REQ-035 Reset mid-poll: rst at cycle 5 of START -> poll_start=0 next cycle; all registers read 8'h00; next frame_tick runs a full poll.
REQ-036 Boundaries: unmapped addr 4'hF reads 8'h00; CAPTURE coincident with press read -> retains only new edges (e.g. old 8'h01, new edge 8'h02 -> 8'h02).
REQ-037 With CONTROLLER_REGS_RELEASE_EN: 8'hFE then 8'h00 captured -> addr 2 (rel_0) reads 8'hFE; status at addr 6.
